// File: rtl/core_mem_arb_pkg.sv
// rtl/core_mem_arb_pkg.sv - shared state, owner and grant encodings for the core memory arbiter
package core_mem_arb_pkg;

    localparam int CORE_ARB_ADDR_W = 32;
    localparam int CORE_ARB_DATA_W = 64;
    localparam int CORE_ARB_MASK_W = CORE_ARB_DATA_W / 8;

    typedef enum logic [1:0] {
        CORE_ARB_IDLE = 2'd0,
        CORE_ARB_REQ  = 2'd1,
        CORE_ARB_RSP  = 2'd2
    } arb_state_t;

    localparam logic CORE_ARB_OWN_IFU = 1'b0;
    localparam logic CORE_ARB_OWN_LSU = 1'b1;

    // One-hot grant: bit 0 = IFU, bit 1 = LSU
    localparam logic [1:0] CORE_ARB_GNT_NONE = 2'b00;
    localparam logic [1:0] CORE_ARB_GNT_IFU  = 2'b01;
    localparam logic [1:0] CORE_ARB_GNT_LSU  = 2'b10;

endpackage

// File: rtl/core_mem_arb_sel.sv
// rtl/core_mem_arb_sel.sv - two-way grant select; CORE_MEM_ARB_RR_EN picks round-robin over fixed LSU priority
module core_mem_arb_sel
    import core_mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifdef CORE_MEM_ARB_RR_EN
    // On a tie the requester that did not win last time goes next
    always_comb begin
        grant = CORE_ARB_GNT_NONE;
        if (ifu_valid && lsu_valid) begin
            grant = (last_grant == CORE_ARB_OWN_LSU) ? CORE_ARB_GNT_IFU : CORE_ARB_GNT_LSU;
        end else if (lsu_valid) begin
            grant = CORE_ARB_GNT_LSU;
        end else if (ifu_valid) begin
            grant = CORE_ARB_GNT_IFU;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = CORE_ARB_GNT_NONE;
        if (lsu_valid) begin
            grant = CORE_ARB_GNT_LSU;
        end else if (ifu_valid) begin
            grant = CORE_ARB_GNT_IFU;
        end
    end
`endif

endmodule

// File: rtl/core_mem_arb.sv
// rtl/core_mem_arb.sv - IFU/LSU to single memory port arbiter, one outstanding transaction; CORE_MEM_ARB_RR_EN enables round-robin
module core_mem_arb
    import core_mem_arb_pkg::*;
#(
    parameter int ADDR_W = CORE_ARB_ADDR_W,
    parameter int DATA_W = CORE_ARB_DATA_W,
    parameter int MASK_W = CORE_ARB_MASK_W
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_req_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rsp_rdata,

    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_req_addr,
    input  logic              lsu_req_wen,
    input  logic [DATA_W-1:0] lsu_req_wdata,
    input  logic [MASK_W-1:0] lsu_req_wmask,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rsp_rdata,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_wen,
    output logic [DATA_W-1:0] mem_req_wdata,
    output logic [MASK_W-1:0] mem_req_wmask,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rsp_rdata
);

    arb_state_t        state_q, state_d;
    logic              owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic [1:0]        grant;
    logic              last_grant;
    logic              idle;
    logic              ifu_accept;
    logic              lsu_accept;
    logic              owner_rsp_ready;

    core_mem_arb_sel u_sel (
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    assign idle       = (state_q == CORE_ARB_IDLE);
    assign ifu_accept = idle && ifu_req_valid && grant[0];
    assign lsu_accept = idle && lsu_req_valid && grant[1];

    assign owner_rsp_ready = (owner_q == CORE_ARB_OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready;

`ifdef CORE_MEM_ARB_RR_EN
    logic last_grant_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= CORE_ARB_OWN_IFU;
        end else if (ifu_accept || lsu_accept) begin
            last_grant_q <= lsu_accept ? CORE_ARB_OWN_LSU : CORE_ARB_OWN_IFU;
        end
    end

    assign last_grant = last_grant_q;
`else
    assign last_grant = CORE_ARB_OWN_IFU;
`endif

    always_comb begin
        state_d       = state_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        ifu_rsp_rdata = '0;
        lsu_rsp_rdata = '0;

        case (state_q)
            CORE_ARB_IDLE: begin
                ifu_req_ready = grant[0];
                lsu_req_ready = grant[1];
                if (ifu_accept || lsu_accept) begin
                    state_d = CORE_ARB_REQ;
                end
            end
            CORE_ARB_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = CORE_ARB_RSP;
                end
            end
            CORE_ARB_RSP: begin
                mem_rsp_ready = owner_rsp_ready;
                ifu_rsp_rdata = mem_rsp_rdata;
                lsu_rsp_rdata = mem_rsp_rdata;
                if (owner_q == CORE_ARB_OWN_LSU) begin
                    lsu_rsp_valid = mem_rsp_valid;
                end else begin
                    ifu_rsp_valid = mem_rsp_valid;
                end
                if (mem_rsp_valid && owner_rsp_ready) begin
                    state_d = CORE_ARB_IDLE;
                end
            end
            default: begin
                state_d = CORE_ARB_IDLE;
            end
        endcase
    end

    // Requesters may drop valid after the handshake, so the request is held here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CORE_ARB_IDLE;
            owner_q <= CORE_ARB_OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            state_q <= state_d;
            if (lsu_accept) begin
                owner_q <= CORE_ARB_OWN_LSU;
                addr_q  <= lsu_req_addr;
                wen_q   <= lsu_req_wen;
                wdata_q <= lsu_req_wdata;
                wmask_q <= lsu_req_wmask;
            end else if (ifu_accept) begin
                owner_q <= CORE_ARB_OWN_IFU;
                addr_q  <= ifu_req_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    assign mem_req_addr  = addr_q;
    assign mem_req_wen   = wen_q;
    assign mem_req_wdata = wdata_q;
    assign mem_req_wmask = wmask_q;

endmodule

// File: tb/tb_core_mem_arb.sv
// tb/tb_core_mem_arb.sv - self-checking bench for core_mem_arb (honours CORE_MEM_ARB_RR_EN)
module tb_core_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [31:0] ifu_req_addr;
    logic [63:0] ifu_rsp_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [31:0] lsu_req_addr;
    logic [63:0] lsu_req_wdata, lsu_rsp_rdata;
    logic [7:0]  lsu_req_wmask;
    logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid, mem_rsp_ready;
    logic [31:0] mem_req_addr;
    logic [63:0] mem_req_wdata, mem_rsp_rdata;
    logic [7:0]  mem_req_wmask;

    int vectors     = 0;
    int miscompares = 0;
    int ifu_grants  = 0;
    int lsu_grants  = 0;
    bit model_last  = 1'b0;   // 1 = LSU was granted last

    core_mem_arb dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wen(lsu_req_wen), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ifu_v;
        logic lsu_v;
        logic exp_ifu_rdy;
        logic exp_lsu_rdy;
    } arb_vec_t;

    arb_vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit tie_goes_lsu();
`ifdef CORE_MEM_ARB_RR_EN
        return !model_last;
`else
        return 1'b1;
`endif
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, " req_readys"}, 64'({ifu_req_ready, lsu_req_ready}), 64'd0);
        check({tag, " rsp_valids"}, 64'({ifu_rsp_valid, lsu_rsp_valid}), 64'd0);
        check({tag, " ifu_rsp_rdata"}, ifu_rsp_rdata, 64'd0);
        check({tag, " lsu_rsp_rdata"}, lsu_rsp_rdata, 64'd0);
        check({tag, " mem_valid_ready"}, 64'({mem_req_valid, mem_rsp_ready}), 64'd0);
        check({tag, " mem_req_addr"}, 64'(mem_req_addr), 64'd0);
        check({tag, " mem_req_wdata"}, mem_req_wdata, 64'd0);
        check({tag, " mem_req_wen_wmask"}, 64'({mem_req_wen, mem_req_wmask}), 64'd0);
    endtask

    // Runs one full transaction from the IDLE accept through the response handshake
    task automatic one_txn(input bit gen, input bit saturate, input int req_wait,
                           input int rsp_hold, input bit fixed_rd, input logic [63:0] rd);
        logic        e_lsu;
        logic [31:0] e_addr;
        logic        e_wen;
        logic [63:0] e_wdata;
        logic [7:0]  e_wmask;
        logic        own_rdy;
        bit          done;

        if (saturate || gen) begin
            if (!ifu_req_valid && (saturate || $urandom_range(0, 1) == 1)) begin
                ifu_req_valid = 1'b1;
                ifu_req_addr  = $urandom;
            end
            if (!lsu_req_valid && (saturate || $urandom_range(0, 1) == 1)) begin
                lsu_req_valid = 1'b1;
                lsu_req_addr  = $urandom;
                lsu_req_wen   = 1'($urandom_range(0, 1));
                lsu_req_wdata = {$urandom, $urandom};
                lsu_req_wmask = 8'($urandom_range(0, 255));
            end
            if (!ifu_req_valid && !lsu_req_valid) begin
                ifu_req_valid = 1'b1;
                ifu_req_addr  = $urandom;
            end
        end
        #1;
        e_lsu = lsu_req_valid && (!ifu_req_valid || tie_goes_lsu());
        check("ifu_req_ready", 64'(ifu_req_ready), 64'(ifu_req_valid && !e_lsu));
        check("lsu_req_ready", 64'(lsu_req_ready), 64'(e_lsu));
        e_addr  = e_lsu ? lsu_req_addr : ifu_req_addr;
        e_wen   = e_lsu ? lsu_req_wen : 1'b0;
        e_wdata = lsu_req_wdata;
        e_wmask = e_lsu ? lsu_req_wmask : 8'h00;
        model_last = e_lsu;
        if (e_lsu) lsu_grants++; else ifu_grants++;
        step();

        // The winner walks away and scribbles its bus; the latched copy must survive
        if (e_lsu) begin
            lsu_req_valid = 1'b0;
            lsu_req_addr  = ~lsu_req_addr;
            lsu_req_wdata = ~lsu_req_wdata;
            lsu_req_wmask = ~lsu_req_wmask;
            lsu_req_wen   = ~lsu_req_wen;
        end else begin
            ifu_req_valid = 1'b0;
            ifu_req_addr  = ~ifu_req_addr;
        end

        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;
        for (int w = 0; w <= req_wait; w++) begin
            mem_req_ready = (w == req_wait);
            mem_rsp_valid = (w == req_wait) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            check("mem_req_valid", 64'(mem_req_valid), 64'd1);
            check("mem_req_addr", 64'(mem_req_addr), 64'(e_addr));
            check("mem_req_wen_wmask", 64'({mem_req_wen, mem_req_wmask}), 64'({e_wen, e_wmask}));
            if (e_lsu) check("mem_req_wdata", mem_req_wdata, e_wdata);
            check("req_hold_quiet", 64'({mem_rsp_ready, ifu_rsp_valid, lsu_rsp_valid,
                                         ifu_req_ready, lsu_req_ready}), 64'd0);
            step();
        end
        mem_req_ready = 1'b0;

        done = 1'b0;
        for (int c = 0; c < 32 && !done; c++) begin
            if (c < rsp_hold) begin
                mem_rsp_valid = 1'b1;
                own_rdy       = 1'b0;
            end else begin
                mem_rsp_valid = (c >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
                own_rdy       = (c >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            if (e_lsu) begin
                lsu_rsp_ready = own_rdy;
                ifu_rsp_ready = 1'($urandom_range(0, 1));
            end else begin
                ifu_rsp_ready = own_rdy;
                lsu_rsp_ready = 1'($urandom_range(0, 1));
            end
            mem_rsp_rdata = fixed_rd ? rd : {$urandom, $urandom};
            #1;
            check("mem_rsp_ready", 64'(mem_rsp_ready), 64'(own_rdy));
            check("owner_rsp_valid", 64'(e_lsu ? lsu_rsp_valid : ifu_rsp_valid), 64'(mem_rsp_valid));
            check("other_rsp_valid", 64'(e_lsu ? ifu_rsp_valid : lsu_rsp_valid), 64'd0);
            check("ifu_rsp_rdata", ifu_rsp_rdata, mem_rsp_rdata);
            check("lsu_rsp_rdata", lsu_rsp_rdata, mem_rsp_rdata);
            check("rsp_mem_req_valid", 64'(mem_req_valid), 64'd0);
            done = mem_rsp_valid && own_rdy;
            step();
        end
        if (!done) begin
            miscompares++;
            $display("FAIL rsp_timeout: got no response handshake expected one within 32 cycles");
        end
        mem_rsp_valid = 1'b0;
        ifu_rsp_ready = 1'b0;
        lsu_rsp_ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

    initial begin
        int lsu_before;
        int ifu_before;

        tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};   // fresh reset: last grant is IFU in both modes

        rst_n = 1'b0;
        ifu_req_valid = 0; ifu_req_addr = 0; ifu_rsp_ready = 0;
        lsu_req_valid = 0; lsu_req_addr = 0; lsu_req_wen = 0; lsu_req_wdata = 0;
        lsu_req_wmask = 0; lsu_rsp_ready = 0;
        mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 64'h5a5a;
        #12;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step();
            ifu_req_valid = tbl[i].ifu_v;
            lsu_req_valid = tbl[i].lsu_v;
            ifu_req_addr  = 32'h1000_0000 + 32'(i);
            lsu_req_addr  = 32'h2000_0000 + 32'(i);
            #1;
            check("tbl_ifu_ready", 64'(ifu_req_ready), 64'(tbl[i].exp_ifu_rdy));
            check("tbl_lsu_ready", 64'(lsu_req_ready), 64'(tbl[i].exp_lsu_rdy));
            check("tbl_mem_req_valid", 64'(mem_req_valid), 64'd0);
            ifu_req_valid = 1'b0;
            lsu_req_valid = 1'b0;
        end
        step();

        // IFU alone
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0000;
        one_txn(1'b0, 1'b0, 0, 0, 1'b1, 64'h13);

        // Simultaneous IFU fetch and LSU store, with request and response back-pressure
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0004;
        lsu_req_valid = 1'b1;
        lsu_req_addr  = 32'h8000_1000;
        lsu_req_wen   = 1'b1;
        lsu_req_wdata = 64'hDEAD;
        lsu_req_wmask = 8'h0F;
        lsu_before    = lsu_grants;
        one_txn(1'b0, 1'b0, 5, 3, 1'b0, 64'h0);
`ifndef CORE_MEM_ARB_RR_EN
        check("tie_first_is_lsu", 64'(lsu_grants - lsu_before), 64'd1);
`endif
        one_txn(1'b0, 1'b0, 0, 0, 1'b0, 64'h0);

        // Reset asserted while in RSP
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0100;
        #1;
        step();
        ifu_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 64'h1234_5678_9abc_def0;
        ifu_rsp_ready = 1'b0;
        #1;
        check("pre_reset_rsp_valid", 64'(ifu_rsp_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_rsp_reset");
        mem_rsp_valid = 1'b0;
        step();
        rst_n = 1'b1;
        model_last = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_addr  = 32'h8000_0200;
        one_txn(1'b0, 1'b0, 0, 0, 1'b1, 64'h77);

        // Both requesters saturated for 20 transactions
        ifu_before = ifu_grants;
        for (int t = 0; t < 20; t++) begin
            one_txn(1'b0, 1'b1, 0, 0, 1'b0, 64'h0);
        end
`ifdef CORE_MEM_ARB_RR_EN
        check("saturated_ifu_grants", 64'(ifu_grants - ifu_before), 64'd10);
`else
        check("saturated_ifu_grants", 64'(ifu_grants - ifu_before), 64'd0);
`endif
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        step();

        for (int t = 0; t < 60; t++) begin
            one_txn(1'b1, 1'b0, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, 64'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
